// File: rtl/mem_resp_pkg.sv
// Shared types and sizing helpers for the memory responder slice.
package mem_resp_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Index width for a word array of the given depth (at least one bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word storage: synchronous write, registered read on the same edge.
module mem_word_array #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write or read one word when enabled; contents survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[idx] <= wdata;
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Request/response front end for the word store: handshakes, wait states, range check.
module memory_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error
);

    localparam int unsigned         IW      = idx_width(DEPTH_WORDS);
    localparam logic [3:0]          WS      = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH_WORDS);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  access;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign in_range = ({1'b0, addr_q} < DEPTH_A);

    // Next-state logic. The counter runs down to zero in WAIT and the access
    // happens on the following edge, so RESP is entered WAIT_STATES+1 edges
    // after the accept (WAIT is visited even when WAIT_STATES is zero).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WS;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request registers; reset drops any pending operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    mem_word_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_WIDTH  (IW)
    ) u_array (
        .clk  (clk),
        .en   (access),
        .we   (write_q && in_range),
        .idx  (addr_q[IW-1:0]),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    // Response outputs; read data only shows for in-range reads.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_error = (state_q == RESP) && !in_range;
        resp_rdata = '0;
        if ((state_q == RESP) && !write_q && in_range) begin
            resp_rdata = arr_rdata;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: table of transactions plus hand-written corner sequences.
module tb_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_error;
    logic [15:0] a_req_addr;
    logic [31:0] a_req_wdata, a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_error;
    logic [15:0] b_req_addr;
    logic [31:0] b_req_wdata, b_resp_rdata;

    memory_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .DEPTH_WORDS(256),
        .WAIT_STATES(2)
    ) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_write (a_req_write),
        .req_addr  (a_req_addr),
        .req_wdata (a_req_wdata),
        .resp_valid(a_resp_valid),
        .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata),
        .resp_error(a_resp_error)
    );

    memory_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .DEPTH_WORDS(256),
        .WAIT_STATES(0)
    ) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_write (b_req_write),
        .req_addr  (b_req_addr),
        .req_wdata (b_req_wdata),
        .resp_valid(b_resp_valid),
        .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata),
        .resp_error(b_resp_error)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called #1 after the accept edge: measures latency, holds the response
    // for 'hold' extra cycles, then completes the response handshake.
    task automatic a_wait_resp(input string tag, input logic [31:0] exp_rdata,
                               input bit exp_err, input int hold);
        int lat;
        logic [31:0] first_rdata;
        lat = 0;
        while (!a_resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd3);
        if (a_resp_valid) begin
            chk({tag, " rdata"}, a_resp_rdata, exp_rdata);
            chk({tag, " error"}, 32'(a_resp_error), 32'(exp_err));
            first_rdata = a_resp_rdata;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk({tag, " hold resp_valid"}, 32'(a_resp_valid), 32'd1);
                chk({tag, " hold rdata"}, a_resp_rdata, first_rdata);
                chk({tag, " hold req_ready"}, 32'(a_req_ready), 32'd0);
            end
            a_resp_ready = 1'b1;
            @(posedge clk); #1;
            a_resp_ready = 1'b0;
            chk({tag, " done resp_valid"}, 32'(a_resp_valid), 32'd0);
            chk({tag, " done req_ready"}, 32'(a_req_ready), 32'd1);
        end
    endtask

    task automatic a_xact(input vec_t v, input string tag);
        chk({tag, " idle req_ready"}, 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1;
        a_req_write = v.write;
        a_req_addr  = v.addr;
        a_req_wdata = v.wdata;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        a_req_write = 1'b0;
        a_req_addr  = '0;
        a_req_wdata = '0;
        a_wait_resp(tag, v.exp_rdata, v.exp_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t v;
        logic exp_rr, exp_rv;

        reset_n      = 1'b0;
        a_req_valid  = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b0;
        b_req_valid  = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b0;

        vecs.push_back('{1'b1, 16'h0005, 32'h5555_5555, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 16'h00FF, 32'h0FF0_0FF0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 16'h0007, 32'hA5A5_A5A5, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 16'h0004, 32'hACED_CAFE, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 16'h0004, 32'h0,         32'hACED_CAFE, 1'b0});
        vecs.push_back('{1'b1, 16'h0003, 32'hDEAD_BEEF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 16'h0005, 32'h0,         32'h5555_5555, 1'b0});
        vecs.push_back('{1'b0, 16'h0003, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 16'h0100, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b1, 16'hFFFF, 32'hBAD0_BAD0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 16'h00FF, 32'h0,         32'h0FF0_0FF0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("reset a req_ready", 32'(a_req_ready), 32'd1);
        chk("reset a resp_valid", 32'(a_resp_valid), 32'd0);
        chk("reset a rdata", a_resp_rdata, 32'h0);
        chk("reset a error", 32'(a_resp_error), 32'd0);
        chk("reset b req_ready", 32'(b_req_ready), 32'd1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            a_xact(vecs[i], $sformatf("vec%0d", i));
        end

        // Response held for 4 cycles while a new request waits; that request
        // must not be accepted on the edge that takes the response.
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 16'h0004;
        @(posedge clk); #1;
        a_req_write = 1'b1; a_req_wdata = 32'h1111_1111;
        a_wait_resp("hold", 32'hACED_CAFE, 1'b0, 4);
        @(posedge clk); #1;
        chk("held req accepted", 32'(a_req_ready), 32'd0);
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        a_wait_resp("held_wr", 32'h0, 1'b0, 0);
        v = '{1'b0, 16'h0004, 32'h0, 32'h1111_1111, 1'b0};
        a_xact(v, "held_rd");

        // Reset during WAIT drops the pending write.
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 16'h0007; a_req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midreset req_ready", 32'(a_req_ready), 32'd1);
        chk("midreset resp_valid", 32'(a_resp_valid), 32'd0);
        chk("midreset rdata", a_resp_rdata, 32'h0);
        chk("midreset error", 32'(a_resp_error), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        v = '{1'b0, 16'h0007, 32'h0, 32'hA5A5_A5A5, 1'b0};
        a_xact(v, "after_reset");

        // Zero wait states, request held high: 3-cycle round trip.
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 16'h0009; b_req_wdata = 32'h600D_F00D;
        b_resp_ready = 1'b1;
        for (int e = 0; e < 9; e++) begin
            @(posedge clk); #1;
            exp_rr = ((e % 3) == 2);
            exp_rv = ((e % 3) == 1);
            chk($sformatf("b e%0d req_ready", e), 32'(b_req_ready), 32'(exp_rr));
            chk($sformatf("b e%0d resp_valid", e), 32'(b_resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk($sformatf("b e%0d rdata", e), b_resp_rdata, (e == 1) ? 32'h0 : 32'h600D_F00D);
            end
            if (e == 2) begin
                b_req_write = 1'b0;
                b_req_wdata = '0;
            end
        end
        b_req_valid = 1'b0; b_resp_ready = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
